// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite word field layout, blitter state encoding and screen defaults
package sprite_pkg;

    localparam int X_MSB    = 15;
    localparam int X_LSB    = 10;
    localparam int Y_MSB    = 9;
    localparam int Y_LSB    = 4;
    localparam int COL_MSB  = 3;
    localparam int COL_LSB  = 1;
    localparam int MORE_BIT = 0;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_WAIT_LD_ENC = 3'd1;
    localparam logic [2:0] ST_ADDR_ENC    = 3'd2;
    localparam logic [2:0] ST_READ_ENC    = 3'd3;
    localparam logic [2:0] ST_EMIT_ENC    = 3'd4;
    localparam logic [2:0] ST_FIN_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_WAIT_LD = ST_WAIT_LD_ENC,
        ST_ADDR    = ST_ADDR_ENC,
        ST_READ    = ST_READ_ENC,
        ST_EMIT    = ST_EMIT_ENC,
        ST_FIN     = ST_FIN_ENC
    } blit_state_t;

endpackage

// File: rtl/sprite_word_unpack.sv
// rtl/sprite_word_unpack.sv - splits a sprite word, offsets it by the sprite origin and decides visibility
module sprite_word_unpack
    import sprite_pkg::*;
#(
    parameter int         SCREEN_W   = SCREEN_W_DEF,
    parameter int         SCREEN_H   = SCREEN_H_DEF,
    parameter int         TRANSP_EN  = 0,
    parameter logic [2:0] TRANSP_COL = 3'b000
) (
    input  logic [15:0] word,
    input  logic [7:0]  base_x,
    input  logic [6:0]  base_y,
    output logic [8:0]  sx,
    output logic [7:0]  sy,
    output logic [2:0]  colour,
    output logic        more,
    output logic        visible
);

    logic w_transp;

    // One extra bit on each sum so off-screen positions clip instead of wrapping onto the screen.
    assign sx       = {1'b0, base_x} + {3'b000, word[X_MSB:X_LSB]};
    assign sy       = {1'b0, base_y} + {2'b00, word[Y_MSB:Y_LSB]};
    assign colour   = word[COL_MSB:COL_LSB];
    assign more     = word[MORE_BIT];
    assign w_transp = (TRANSP_EN != 0) && (colour == TRANSP_COL);
    assign visible  = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H)) && !w_transp;

endmodule

// File: rtl/sprite_blit_ctrl.sv
// rtl/sprite_blit_ctrl.sv - walks sprite RAM from address 0 and emits one clipped plot per word
module sprite_blit_ctrl
    import sprite_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter int         MAX_WORDS  = 1024,
    parameter int         RD_LAT     = 1,
    parameter int         SCREEN_W   = SCREEN_W_DEF,
    parameter int         SCREEN_H   = SCREEN_H_DEF,
    parameter int         TRANSP_EN  = 0,
    parameter logic [2:0] TRANSP_COL = 3'b000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        base_x,
    input  logic [6:0]        base_y,
    input  logic              loader_busy,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_q,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              plot,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT);

    blit_state_t       r_state;
    blit_state_t       w_next;
    logic [7:0]        r_base_x;
    logic [6:0]        r_base_y;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_lat_cnt;
    logic              r_word_more;
    logic [7:0]        r_vga_x;
    logic [6:0]        r_vga_y;
    logic [2:0]        r_vga_colour;
    logic              r_plot;
    logic              r_err;

    logic [8:0] w_sx;
    logic [7:0] w_sy;
    logic [2:0] w_colour;
    logic       w_more;
    logic       w_visible;
    logic       w_word_ready;
    logic       w_at_limit;
    logic       w_unused;

    sprite_word_unpack #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .TRANSP_EN (TRANSP_EN),
        .TRANSP_COL(TRANSP_COL)
    ) u_unpack (
        .word   (ram_q),
        .base_x (r_base_x),
        .base_y (r_base_y),
        .sx     (w_sx),
        .sy     (w_sy),
        .colour (w_colour),
        .more   (w_more),
        .visible(w_visible)
    );

    // Overflow bits only matter for clipping, which the unpacker already folds into visible.
    assign w_unused     = ^{w_sx[8], w_sy[7]};
    assign w_word_ready = (r_state == ST_READ) && (r_lat_cnt == 2'd1);
    assign w_at_limit   = (r_addr == LAST_ADDR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_WAIT_LD;
            ST_WAIT_LD: if (!loader_busy) w_next = ST_ADDR;
            ST_ADDR:    w_next = loader_busy ? ST_WAIT_LD : ST_READ;
            ST_READ:    if (w_word_ready) w_next = ST_EMIT;
            ST_EMIT:    w_next = (!r_word_more || w_at_limit) ? ST_FIN : ST_ADDR;
            ST_FIN:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Plot fields are registered on the READ->EMIT edge so they are valid during EMIT and hold afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base_x     <= '0;
            r_base_y     <= '0;
            r_addr       <= '0;
            r_lat_cnt    <= '0;
            r_word_more  <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_plot       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base_x <= base_x;
                        r_base_y <= base_y;
                        r_addr   <= '0;
                        r_err    <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (!loader_busy) r_lat_cnt <= LAT_INIT;
                end
                ST_READ: begin
                    r_lat_cnt <= r_lat_cnt - 2'd1;
                    if (w_word_ready) begin
                        r_word_more  <= w_more;
                        r_vga_x      <= w_sx[7:0];
                        r_vga_y      <= w_sy[6:0];
                        r_vga_colour <= w_colour;
                        r_plot       <= w_visible;
                    end
                end
                ST_EMIT: begin
                    if (r_word_more) begin
                        if (w_at_limit) r_err <= 1'b1;
                        else            r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr   = r_addr;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign plot       = r_plot;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done       = (r_state == ST_FIN);
    assign err        = r_err;

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// tb/tb_sprite_blit_ctrl.sv - scoreboard bench for sprite_blit_ctrl with a list-level reference model
module tb_sprite_blit_ctrl;

    typedef struct {
        int dut;
        int kind;
        int x;
        int y;
        int col;
        int err;
        int cyc;
    } ev_t;

    logic        clk;
    logic        resetn;
    logic        start_s [2];
    logic [7:0]  bx_s    [2];
    logic [6:0]  by_s    [2];
    logic        lb_s    [2];
    logic [9:0]  addr_w  [2];
    logic [7:0]  x_w     [2];
    logic [6:0]  y_w     [2];
    logic [2:0]  col_w   [2];
    logic        plot_w  [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic [15:0] q0, p1a, p1b, q1;
    logic [15:0] mem [0:1023];

    int  lat_of  [2] = '{1, 3};
    int  maxw_of [2] = '{8, 16};
    bit  tren_of [2] = '{1'b1, 1'b0};
    int  done_cnt[2] = '{0, 0};
    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  exp_err_g, exp_last_g, last_n;

    sprite_blit_ctrl #(.ADDR_W(10), .MAX_WORDS(8), .RD_LAT(1), .TRANSP_EN(1), .TRANSP_COL(3'b111)) dut0 (
        .clk(clk), .resetn(resetn), .start(start_s[0]), .base_x(bx_s[0]), .base_y(by_s[0]),
        .loader_busy(lb_s[0]), .ram_addr(addr_w[0]), .ram_q(q0), .vga_x(x_w[0]), .vga_y(y_w[0]),
        .vga_colour(col_w[0]), .plot(plot_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    sprite_blit_ctrl #(.ADDR_W(10), .MAX_WORDS(16), .RD_LAT(3), .TRANSP_EN(0), .TRANSP_COL(3'b000)) dut1 (
        .clk(clk), .resetn(resetn), .start(start_s[1]), .base_x(bx_s[1]), .base_y(by_s[1]),
        .loader_busy(lb_s[1]), .ram_addr(addr_w[1]), .ram_q(q1), .vga_x(x_w[1]), .vga_y(y_w[1]),
        .vga_colour(col_w[1]), .plot(plot_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        q0  <= mem[addr_w[0]];
        p1a <= mem[addr_w[1]];
        p1b <= p1a;
        q1  <= p1b;
    end

    task automatic chk(string nm, int act, int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d required=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_event(int d, int kind, int x, int y, int col, int e);
        ev_t ex;
        total = total + 1;
        if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_event dut=%0d kind=%0d got x=%0d y=%0d col=%0d err=%0d cyc=%0d required none",
                     d, kind, x, y, col, e, cyc);
        end else begin
            ex = exp_q.pop_front();
            if (ex.dut != d || ex.kind != kind ||
                (kind == 0 && (ex.x != x || ex.y != y || ex.col != col)) ||
                (kind == 1 && ex.err != e) || (ex.cyc >= 0 && ex.cyc != cyc)) begin
                bad = bad + 1;
                $display("FAIL event dut=%0d got kind=%0d x=%0d y=%0d col=%0d err=%0d cyc=%0d required dut=%0d kind=%0d x=%0d y=%0d col=%0d err=%0d cyc=%0d",
                         d, kind, x, y, col, e, cyc, ex.dut, ex.kind, ex.x, ex.y, ex.col, ex.err, ex.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            for (int k = 0; k < 2; k++) begin
                if (plot_w[k]) mon_event(k, 0, int'(x_w[k]), int'(y_w[k]), int'(col_w[k]), 0);
                if (done_w[k]) begin
                    done_cnt[k] = done_cnt[k] + 1;
                    mon_event(k, 1, 0, 0, 0, int'(err_w[k]));
                end
            end
        end
    end

    function automatic logic [15:0] mk(int x, int y, int c, int m);
        logic [5:0] xf, yf;
        logic [2:0] cf;
        xf = 6'(x);
        yf = 6'(y);
        cf = 3'(c);
        return {xf, yf, cf, (m != 0)};
    endfunction

    // Reference: plot list, err and final address follow directly from the word list and the screen rules.
    task automatic expect_blit(int d, int bx, int by, int n0, bit timed);
        int L, sx, sy, col, last;
        bit more, vis;
        logic [15:0] w;
        ev_t ev;
        L = lat_of[d];
        last = 0;
        more = 1'b0;
        for (int i = 0; i < maxw_of[d]; i++) begin
            w    = mem[i];
            sx   = bx + int'(w[15:10]);
            sy   = by + int'(w[9:4]);
            col  = int'(w[3:1]);
            vis  = (sx < 160) && (sy < 120) && !(tren_of[d] && col == 7);
            if (vis) begin
                ev.dut = d; ev.kind = 0; ev.x = sx; ev.y = sy; ev.col = col; ev.err = 0;
                ev.cyc = timed ? n0 + L + 3 + i * (L + 2) : -1;
                exp_q.push_back(ev);
            end
            last = i;
            more = w[0];
            if (!more) break;
        end
        ev.dut = d; ev.kind = 1; ev.x = 0; ev.y = 0; ev.col = 0; ev.err = more ? 1 : 0;
        ev.cyc = timed ? n0 + L + 3 + last * (L + 2) + 1 : -1;
        exp_q.push_back(ev);
        exp_err_g  = more ? 1 : 0;
        exp_last_g = last;
    endtask

    task automatic start_blit(int d, int bx, int by, bit timed, bit lb_hold);
        @(posedge clk); #1;
        start_s[d] = 1'b1;
        bx_s[d]    = 8'(bx);
        by_s[d]    = 7'(by);
        if (lb_hold) lb_s[d] = 1'b1;
        last_n = cyc;
        expect_blit(d, bx, by, cyc, timed);
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        bx_s[d]    = 8'($urandom);
        by_s[d]    = 7'($urandom);
    endtask

    task automatic drain(int d, bit rnd_lb, int lim);
        for (int k = 0; k < lim; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
            if (rnd_lb) lb_s[d] = ($urandom_range(0, 2) == 0);
        end
        lb_s[d] = 1'b0;
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end else begin
            chk("busy_after_done", int'(busy_w[d]), 0);
            chk("err_after_done", int'(err_w[d]), exp_err_g);
            chk("addr_after_done", int'(addr_w[d]), exp_last_g);
        end
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero(int d, string tag);
        chk({tag, "_addr"}, int'(addr_w[d]), 0);
        chk({tag, "_vga_x"}, int'(x_w[d]), 0);
        chk({tag, "_vga_y"}, int'(y_w[d]), 0);
        chk({tag, "_colour"}, int'(col_w[d]), 0);
        chk({tag, "_plot"}, int'(plot_w[d]), 0);
        chk({tag, "_busy"}, int'(busy_w[d]), 0);
        chk({tag, "_done"}, int'(done_w[d]), 0);
        chk({tag, "_err"}, int'(err_w[d]), 0);
    endtask

    task automatic load_t1();
        mem[0] = mk(0, 0, 5, 1);
        mem[1] = mk(1, 0, 5, 1);
        mem[2] = mk(1, 1, 2, 0);
    endtask

    initial begin
        int n, d0, len, dsel;
        bit seen, stall;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; bx_s[k] = '0; by_s[k] = '0; lb_s[k] = 1'b0;
        end
        #3;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        @(posedge clk); #1;
        resetn = 1'b1;

        // basic three-word sprite
        load_t1();
        start_blit(0, 10, 20, 1'b1, 1'b0);
        drain(0, 1'b0, 500);

        // horizontal/vertical clipping and transparency keep the walk going
        mem[0] = mk(40, 0, 1, 1);
        mem[1] = mk(2, 3, 4, 1);
        mem[2] = mk(5, 63, 6, 1);
        mem[3] = mk(9, 1, 7, 1);
        mem[4] = mk(0, 0, 3, 0);
        start_blit(0, 150, 100, 1'b1, 1'b0);
        drain(0, 1'b0, 500);

        // loader stall at start and while addressing word 2
        load_t1();
        start_blit(0, 10, 20, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        lb_s[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (plot_w[0]) begin seen = 1'b1; break; end
        end
        chk("stall_first_plot_seen", int'(seen), 1);
        @(posedge clk); #1;
        lb_s[0] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("stall_addr_held", int'(addr_w[0]), 1);
        end
        @(posedge clk); #1;
        lb_s[0] = 1'b0;
        drain(0, 1'b0, 500);

        // no last word: MAX_WORDS ends the walk with err, next start clears it
        for (int i = 0; i < 8; i++) mem[i] = mk(i, i, 1, 1);
        d0 = done_cnt[0];
        start_blit(0, 5, 5, 1'b1, 1'b0);
        drain(0, 1'b0, 500);
        chk("maxw_done_count", done_cnt[0] - d0, 1);
        load_t1();
        start_blit(0, 10, 20, 1'b1, 1'b0);
        chk("err_cleared_on_start", int'(err_w[0]), 0);
        drain(0, 1'b0, 500);

        // start mid-blit and during FIN is ignored; start right after done is accepted
        load_t1();
        d0 = done_cnt[0];
        start_blit(0, 10, 20, 1'b1, 1'b0);
        n = last_n;
        wait_cyc(n + 6);
        start_s[0] = 1'b1; bx_s[0] = 8'd60; by_s[0] = 7'd60;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_cyc(n + 11);
        start_s[0] = 1'b1; bx_s[0] = 8'd77; by_s[0] = 7'd7;
        start_blit(0, 30, 40, 1'b1, 1'b0);
        drain(0, 1'b0, 500);
        chk("ignored_start_done_count", done_cnt[0] - d0, 2);

        // asynchronous reset during READ of word 4
        for (int i = 0; i < 6; i++) mem[i] = mk(i, 2 * i, i + 1, (i < 5) ? 1 : 0);
        start_blit(0, 3, 4, 1'b1, 1'b0);
        n = last_n;
        wait_cyc(n + 12);
        #2;
        resetn = 1'b0;
        #1;
        chk_zero(0, "midreset");
        exp_q.delete();
        d0 = done_cnt[0];
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("midreset_no_done", done_cnt[0] - d0, 0);
        start_blit(0, 3, 4, 1'b1, 1'b0);
        drain(0, 1'b0, 500);

        // three-word sprite again on the RD_LAT=3 instance
        load_t1();
        start_blit(1, 10, 20, 1'b1, 1'b0);
        drain(1, 1'b0, 500);

        // randomized sprites, positions and loader stalls
        for (int it = 0; it < 24; it++) begin
            dsel  = it % 2;
            len   = $urandom_range(1, maxw_of[dsel] + 3);
            stall = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++)
                mem[i] = mk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 7),
                            (i < len - 1) ? 1 : 0);
            start_blit(dsel, $urandom_range(0, 255), $urandom_range(0, 127), !stall, 1'b0);
            drain(dsel, stall, 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
